// File: rtl/tsn_switch_pkg.sv
// Shared definitions for the TSN switch datapath: AXIS width defaults,
// tuser field layout and the input arbiter FSM encoding.
package tsn_switch_pkg;

    localparam int DEF_AXIS_DATA_WIDTH  = 256;
    localparam int DEF_AXIS_TUSER_WIDTH = 128;

    // tuser layout written by the MAC/DMA front ends; the arbiter never touches it.
    localparam int TUSER_LEN_LSB      = 0;
    localparam int TUSER_LEN_MSB      = 15;
    localparam int TUSER_SRC_PORT_LSB = 16;
    localparam int TUSER_SRC_PORT_MSB = 23;
    localparam int TUSER_DST_PORT_LSB = 24;
    localparam int TUSER_DST_PORT_MSB = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FWD  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_input_fifo.sv
// First-word-fall-through buffer for one arbiter ingress port. The write-side
// ready is registered from the post-update full condition.
module arb_input_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_en
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;
    logic [DEPTH_BITS:0] wr_ptr_nxt;
    logic [DEPTH_BITS:0] rd_ptr_nxt;
    logic                wr_en;
    logic                rd_fire;
    logic                full_nxt;
    logic                ready_q;

    assign wr_en      = wr_valid & ready_q;
    assign rd_fire    = rd_en & rd_valid;
    assign wr_ptr_nxt = wr_ptr + {{DEPTH_BITS{1'b0}}, wr_en};
    assign rd_ptr_nxt = rd_ptr + {{DEPTH_BITS{1'b0}}, rd_fire};
    assign full_nxt   = (wr_ptr_nxt[DEPTH_BITS] != rd_ptr_nxt[DEPTH_BITS]) &&
                        (wr_ptr_nxt[DEPTH_BITS-1:0] == rd_ptr_nxt[DEPTH_BITS-1:0]);

    // ready_q stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            ready_q <= ~full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr[DEPTH_BITS-1:0]];
    assign rd_valid = (wr_ptr != rd_ptr);
    assign wr_ready = ready_q;

endmodule

// File: rtl/tsn_input_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS AXI4-Stream ingress ports
// into one stream; frames are never interleaved.
module tsn_input_arbiter
    import tsn_switch_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int AXIS_DATA_WIDTH  = DEF_AXIS_DATA_WIDTH,
    parameter int AXIS_TUSER_WIDTH = DEF_AXIS_TUSER_WIDTH,
    parameter int FIFO_DEPTH_BITS  = 4
) (
    input  logic                                  axis_aclk,
    input  logic                                  axis_reset,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    input  logic [NUM_PORTS-1:0]                  s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast
);

    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int BEAT_W = AXIS_DATA_WIDTH + KEEP_W + AXIS_TUSER_WIDTH + 1;
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Handshake rule on every AXIS interface here: a beat transfers on a rising
    // clock edge where valid and ready are both high; valid never drops and
    // payload never changes until that transfer happens.

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic [PORT_W-1:0]   grant;
    logic [PORT_W-1:0]   last_grant;
    logic [PORT_W-1:0]   pick;
    logic                pick_found;
    logic                pop;
    logic [BEAT_W-1:0]   head [NUM_PORTS];
    logic [NUM_PORTS-1:0] nonempty;
    logic [NUM_PORTS-1:0] rd_en;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        arb_input_fifo #(
            .WIDTH      (BEAT_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk      (axis_aclk),
            .rst      (axis_reset),
            .wr_data  ({s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH],
                        s_axis_tkeep[i*KEEP_W +: KEEP_W],
                        s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH],
                        s_axis_tlast[i]}),
            .wr_valid (s_axis_tvalid[i]),
            .wr_ready (s_axis_tready[i]),
            .rd_data  (head[i]),
            .rd_valid (nonempty[i]),
            .rd_en    (rd_en[i])
        );
        assign rd_en[i] = pop && (grant == PORT_W'(i));
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_found) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    // Scan starts one past the last winner so every pending port is served in turn.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!pick_found && nonempty[idx]) begin
                pick       = PORT_W'(idx);
                pick_found = 1'b1;
            end
        end
        state_nxt = state;
        case (state)
            ST_IDLE: if (pick_found) state_nxt = ST_FWD;
            ST_FWD:  if (pop && m_axis_tlast) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        if (state == ST_FWD) begin
            m_axis_tvalid = nonempty[grant];
            {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = head[grant];
        end
    end

    assign pop = m_axis_tvalid & m_axis_tready;

endmodule
